// File: rtl/uart_pkg.sv
// Shared definitions for the board UART link: transmitter state encoding, frame
// length and the fractional baud increment used by both uart_tx and uart_rc.
package uart_pkg;

    typedef enum logic [3:0] {
        TX_IDLE  = 4'd0,
        TX_START = 4'd1,
        TX_BIT0  = 4'd2,
        TX_BIT1  = 4'd3,
        TX_BIT2  = 4'd4,
        TX_BIT3  = 4'd5,
        TX_BIT4  = 4'd6,
        TX_BIT5  = 4'd7,
        TX_BIT6  = 4'd8,
        TX_BIT7  = 4'd9,
        TX_STOP  = 4'd10
    } tx_state_e;

    localparam int unsigned FRAME_BITS = 32'd10;

    // Rounded increment so that the accumulator carries once per bit period.
    function automatic longint unsigned baud_inc(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input int unsigned     acc_width
    );
        return ((baud << (acc_width - 32'd4)) + (clk_hz >> 5)) / (clk_hz >> 4);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock register FIFO holding bytes waiting to be serialised; full writes
// and empty reads are ignored, status flags are registered from the next level.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned Aw = 32'd2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          ready,
    output logic          empty,
    output logic [Aw:0]   level
);

    localparam int unsigned DEPTH   = 32'd1 << Aw;
    localparam logic [Aw:0] DEPTH_C = {1'b1, {Aw{1'b0}}};

    logic [7:0]    mem_r [0:DEPTH-1];
    logic [Aw-1:0] wr_ptr_r;
    logic [Aw-1:0] rd_ptr_r;
    logic [Aw:0]   level_r;
    logic [Aw:0]   level_n_s;
    logic          ready_r;
    logic          empty_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push & ready_r;
    assign pop_ok_s  = pop & ~empty_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        level_n_s = level_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_n_s = level_r + (Aw+1)'(32'd1);
            2'b01:   level_n_s = level_r - (Aw+1)'(32'd1);
            default: level_n_s = level_r;
        endcase
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, level and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {Aw{1'b0}};
            rd_ptr_r <= {Aw{1'b0}};
            level_r  <= {(Aw+1){1'b0}};
            ready_r  <= 1'b1;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + Aw'(32'd1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + Aw'(32'd1);
            end
            level_r <= level_n_s;
            ready_r <= (level_n_s != DEPTH_C);
            empty_r <= (level_n_s == {(Aw+1){1'b0}});
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign ready = ready_r;
    assign empty = empty_r;
    assign level = level_r;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line, with a small byte queue in front
// and a fractional accumulator producing the 1x baud tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned ClkFrequency = 32'd50000000,
    parameter int unsigned Baud         = 32'd115200,
    parameter int unsigned BaudAccWidth = 32'd16,
    parameter int unsigned FifoAw       = 32'd2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              TxD_start,
    input  logic [7:0]        TxD_data,
    output logic              TxD_ready,
    output logic              TxD,
    output logic              TxD_busy,
    output logic [FifoAw:0]   TxD_fifo_level
);

    localparam logic [BaudAccWidth:0] INC_C =
        (BaudAccWidth+1)'(baud_inc(64'(ClkFrequency), 64'(Baud), BaudAccWidth));

    tx_state_e               state_r;
    tx_state_e               state_n_s;
    logic [BaudAccWidth:0]   acc_r;
    logic                    tick_s;
    logic [7:0]              shift_r;
    logic                    txd_r;
    logic                    txd_s;
    logic                    busy_r;
    logic                    busy_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    in_data_s;
    logic [7:0]              fifo_rdata_s;
    logic                    fifo_ready_s;
    logic                    fifo_empty_s;
    logic [FifoAw:0]         fifo_level_s;

    assign push_s    = TxD_start & fifo_ready_s;
    assign tick_s    = acc_r[BaudAccWidth];
    assign in_data_s = (state_r >= TX_BIT0) && (state_r <= TX_BIT7);

    uart_tx_fifo #(
        .Aw (FifoAw)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (TxD_data),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .ready (fifo_ready_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Baud accumulator; it restarts on the frame-start edge so the start bit is a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {(BaudAccWidth+1){1'b0}};
        end else if ((state_r == TX_IDLE) && !pop_s) begin
            acc_r <= {(BaudAccWidth+1){1'b0}};
        end else begin
            acc_r <= {1'b0, acc_r[BaudAccWidth-1:0]} + INC_C;
        end
    end

    // State register plus the registered line and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= TX_IDLE;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            txd_r   <= txd_s;
            busy_r  <= busy_s;
        end
    end

    // Next-state logic; a pop coincides with every entry into START.
    always_comb begin
        state_n_s = state_r;
        pop_s     = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (!fifo_empty_s) begin
                    state_n_s = TX_START;
                    pop_s     = 1'b1;
                end else begin
                    state_n_s = TX_IDLE;
                end
            end
            TX_START, TX_BIT0, TX_BIT1, TX_BIT2, TX_BIT3, TX_BIT4, TX_BIT5, TX_BIT6: begin
                if (tick_s) begin
                    state_n_s = tx_state_e'(state_r + 4'd1);
                end else begin
                    state_n_s = state_r;
                end
            end
            TX_BIT7: begin
                if (tick_s) begin
                    state_n_s = TX_STOP;
                end else begin
                    state_n_s = TX_BIT7;
                end
            end
            TX_STOP: begin
                if (tick_s && !fifo_empty_s) begin
                    state_n_s = TX_START;
                    pop_s     = 1'b1;
                end else if (tick_s) begin
                    state_n_s = TX_IDLE;
                end else begin
                    state_n_s = TX_STOP;
                end
            end
            default: begin
                state_n_s = TX_IDLE;
            end
        endcase
    end

    // Output decode: line level for the current state, busy for the post-update state.
    always_comb begin
        txd_s  = 1'b1;
        busy_s = (state_n_s != TX_IDLE) || (fifo_level_s != {(FifoAw+1){1'b0}}) || push_s;
        case (state_r)
            TX_IDLE:  txd_s = 1'b1;
            TX_START: txd_s = 1'b0;
            TX_STOP:  txd_s = 1'b1;
            default: begin
                if (in_data_s) begin
                    txd_s = shift_r[0];
                end else begin
                    txd_s = 1'b1;
                end
            end
        endcase
    end

    // Shift register: loaded on pop, advanced as each data bit completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= 8'hFF;
        end else if (pop_s) begin
            shift_r <= fifo_rdata_s;
        end else if (tick_s && in_data_s) begin
            shift_r <= {1'b1, shift_r[7:1]};
        end
    end

    assign TxD            = txd_r;
    assign TxD_busy       = busy_r;
    assign TxD_ready      = fifo_ready_s;
    assign TxD_fifo_level = fifo_level_s;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table of single frames, a receiver model
// with a byte scoreboard, and hand-written back-to-back, overflow, reset and baud sequences.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ  = 32'd1000000;
    localparam int unsigned BAUD    = 32'd62500;
    localparam int          BIT_CLK = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       TxD_ready;
    logic       TxD;
    logic       TxD_busy;
    logic [2:0] TxD_fifo_level;

    logic       d_start;
    logic [7:0] d_data;
    logic       d_ready;
    logic       d_txd;
    logic       d_busy;
    logic [2:0] d_level;

    always #5 clk = ~clk;

    uart_tx #(
        .ClkFrequency (CLK_HZ),
        .Baud         (BAUD),
        .BaudAccWidth (32'd16),
        .FifoAw       (32'd2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .TxD_start      (TxD_start),
        .TxD_data       (TxD_data),
        .TxD_ready      (TxD_ready),
        .TxD            (TxD),
        .TxD_busy       (TxD_busy),
        .TxD_fifo_level (TxD_fifo_level)
    );

    uart_tx dut_def (
        .clk            (clk),
        .rst_n          (rst_n),
        .TxD_start      (d_start),
        .TxD_data       (d_data),
        .TxD_ready      (d_ready),
        .TxD            (d_txd),
        .TxD_busy       (d_busy),
        .TxD_fifo_level (d_level)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         rx_count = 0;
    bit         mon_en   = 1'b1;
    bit         sb_en    = 1'b1;
    logic [7:0] sb_q [$];
    int         fall_q [$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;
    vec_t vecs [5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call just after a negedge; holds the strobe across the next rising edge.
    task automatic drive_byte(input logic [7:0] d, output bit accepted);
        TxD_start = 1'b1;
        TxD_data  = d;
        accepted  = (TxD_ready === 1'b1);
        if (accepted && sb_en) sb_q.push_back(d);
        @(negedge clk);
    endtask

    // Receiver model: mid-bit sampling, byte compared against the scoreboard.
    initial begin : rx_monitor
        logic       prev;
        logic [7:0] byte_v;
        logic [7:0] exp_v;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && (rst_n === 1'b1) && (prev === 1'b1) && (TxD === 1'b0)) begin
                fall_q.push_back(cyc);
                repeat (BIT_CLK / 2) @(negedge clk);
                check("rx_start_bit", {31'd0, TxD}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLK) @(negedge clk);
                    byte_v[i] = TxD;
                end
                repeat (BIT_CLK) @(negedge clk);
                check("rx_stop_bit", {31'd0, TxD}, 32'd1);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected_frame: got %02h expected no frame", byte_v);
                end else begin
                    exp_v = sb_q.pop_front();
                    check("rx_byte", {24'd0, byte_v}, {24'd0, exp_v});
                end
                rx_count++;
            end
            prev = TxD;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit         acc;
        int         base;
        int         peak;
        int         t0;
        int         t_prev;
        int         period;
        logic       last;
        bit         found;
        logic [5:0] exp_ready;

        vecs[0] = '{data: 8'h55, frame: 10'b1010101010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'hC3, frame: 10'b1110000110};
        vecs[4] = '{data: 8'h01, frame: 10'b1000000010};

        rst_n = 1'b0; TxD_start = 1'b0; TxD_data = 8'h00;
        d_start = 1'b0; d_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", {26'd0, TxD, TxD_busy, TxD_ready, TxD_fifo_level},
              {26'd0, 1'b1, 1'b0, 1'b1, 3'd0});
        rst_n = 1'b1;

        // 1: idle line after reset
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_state", {26'd0, TxD, TxD_busy, TxD_ready, TxD_fifo_level},
                  {26'd0, 1'b1, 1'b0, 1'b1, 3'd0});
        end

        // 2: table of single frames
        for (int v = 0; v < 5; v++) begin
            base = rx_count;
            drive_byte(vecs[v].data, acc);
            TxD_start = 1'b0;
            check("t2_accepted", {31'd0, acc}, 32'd1);
            check("t2_busy_after_write", {31'd0, TxD_busy}, 32'd1);
            check("t2_line_edge_n", {31'd0, TxD}, 32'd1);
            @(negedge clk);
            check("t2_line_edge_n1", {31'd0, TxD}, 32'd1);
            @(negedge clk);
            check("t2_line_falls_edge_n2", {31'd0, TxD}, 32'd0);
            repeat (BIT_CLK / 2) @(negedge clk);
            for (int k = 0; k < FRAME_BITS; k++) begin
                if (k > 0) repeat (BIT_CLK) @(negedge clk);
                check($sformatf("t2_v%0d_bit%0d", v, k), {31'd0, TxD}, {31'd0, vecs[v].frame[k]});
                if (k == 5) check("t2_busy_mid_frame", {31'd0, TxD_busy}, 32'd1);
            end
            for (int w = 0; w < 64 && TxD_busy !== 1'b0; w++) @(negedge clk);
            check("t2_busy_dropped", {31'd0, TxD_busy}, 32'd0);
            repeat (20) @(negedge clk);
            check("t2_rx_frames", rx_count - base, 32'd1);
        end

        // 3: two bytes back to back
        fall_q.delete();
        base = rx_count;
        drive_byte(8'hA5, acc);
        drive_byte(8'h3C, acc);
        TxD_start = 1'b0;
        for (int w = 0; w < 400 && rx_count < base + 2; w++) @(negedge clk);
        check("t3_rx_frames", rx_count - base, 32'd2);
        check("t3_fall_count", fall_q.size(), 32'd2);
        if (fall_q.size() == 2) check("t3_start_spacing", fall_q[1] - fall_q[0], 32'd160);
        repeat (30) @(negedge clk);

        // 4: six writes into a four-deep queue
        base = rx_count;
        peak = 0;
        exp_ready = 6'b011111;
        fall_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive_byte(8'h10 + 8'(i), acc);
            check($sformatf("t4_ready_write%0d", i), {31'd0, acc}, {31'd0, exp_ready[i]});
            if (int'(TxD_fifo_level) > peak) peak = int'(TxD_fifo_level);
        end
        TxD_start = 1'b0;
        for (int w = 0; w < 1200 && rx_count < base + 5; w++) begin
            @(negedge clk);
            if (int'(TxD_fifo_level) > peak) peak = int'(TxD_fifo_level);
        end
        check("t4_level_peak", peak, 32'd4);
        repeat (200) @(negedge clk);
        check("t4_rx_frames", rx_count - base, 32'd5);
        if (fall_q.size() == 5) check("t4_continuous", fall_q[4] - fall_q[0], 32'd640);
        else check("t4_fall_count", fall_q.size(), 32'd5);

        // 5: reset in the middle of a frame
        mon_en = 1'b0;
        sb_en  = 1'b0;
        drive_byte(8'hFF, acc);
        TxD_start = 1'b0;
        repeat (70) @(negedge clk);
        check("t5_busy_before_reset", {31'd0, TxD_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_reset", {26'd0, TxD, TxD_busy, TxD_ready, TxD_fifo_level},
              {26'd0, 1'b1, 1'b0, 1'b1, 3'd0});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("t5_no_residual", {30'd0, TxD, TxD_busy}, {30'd0, 1'b1, 1'b0});
        end
        mon_en = 1'b1;
        sb_en  = 1'b1;
        base = rx_count;
        drive_byte(8'h3C, acc);
        TxD_start = 1'b0;
        for (int w = 0; w < 250 && rx_count < base + 1; w++) @(negedge clk);
        check("t5_after_reset_frame", rx_count - base, 32'd1);
        repeat (20) @(negedge clk);

        // 6: default parameters, bit period about 434 clk
        d_start = 1'b1;
        d_data  = 8'h55;
        @(negedge clk);
        d_start = 1'b0;
        for (int w = 0; w < 10 && d_txd !== 1'b0; w++) @(negedge clk);
        check("t6_start_fall", {31'd0, d_txd}, 32'd0);
        t0     = cyc;
        t_prev = cyc;
        last   = d_txd;
        for (int k = 0; k < 9; k++) begin
            found = 1'b0;
            for (int w = 0; w < 600 && !found; w++) begin
                @(negedge clk);
                if (d_txd !== last) found = 1'b1;
            end
            last   = d_txd;
            period = cyc - t_prev;
            t_prev = cyc;
            check($sformatf("t6_bit%0d_period_in_2pct(%0d)", k, period),
                  {31'd0, (period >= 425 && period <= 443)}, 32'd1);
        end
        check("t6_stop_level", {31'd0, d_txd}, 32'd1);
        check("t6_nine_bits_in_2pct", {31'd0, ((cyc - t0) >= 3828 && (cyc - t0) <= 3984)}, 32'd1);
        for (int w = 0; w < 600 && d_busy !== 1'b0; w++) @(negedge clk);
        check("t6_busy_dropped", {31'd0, d_busy}, 32'd0);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
